barrier_responder: RTL and testbench
====================================

// Module: barrier_responder
// PURPOSE
//  Memory-mapped barrier target at the interconnect end. NrPorts cores issue requests to BarrierAddr.
//  Each arriving request is held without a response until every port has arrived.
//  All ports are then released together; each one gets the completed barrier's generation number.
//  Requests to any other address get an immediate error response.
// PARAMETERS
//  NrPorts      4              number of requesting cores
//  AddrWidth    32             request address width
//  DataWidth    32             response data width; also the generation counter width
//  BarrierAddr  32'h1234_beef  address that triggers barrier participation
// PORTS
//  clk_i        in   1                    clock
//  rst_i        in   1                    reset, asynchronous, active-high
//  req_valid_i  in   NrPorts              per-port request valid
//  req_addr_i   in   NrPorts x AddrWidth  per-port request address
//  req_ready_o  out  NrPorts              per-port request accept
//  rsp_valid_o  out  NrPorts              per-port response valid
//  rsp_ready_i  in   NrPorts              per-port response accept
//  rsp_data_o   out  NrPorts x DataWidth  generation number of the completed barrier (0 on error)
//  rsp_err_o    out  NrPorts              1 = request address was not BarrierAddr
// BEHAVIOUR
//  Reset:
//  - All ports go to Idle; gen_q=0; rsp_valid_o=0; rsp_data_o=0; rsp_err_o=0.
//  - req_ready_o=0 while rst_i is high, then follows state.
//  Per-port FSM states: Idle, Arrived, Respond.
//  - Idle: req_ready_o=1. Handshake = req_valid_i & req_ready_o.
//    - On handshake with addr==BarrierAddr -> Arrived.
//    - On handshake with any other addr -> Respond, err_q=1, data_q=0.
//  - Arrived: req_ready_o=0, rsp_valid_o=0. Leave only on release.
//  - Respond: rsp_valid_o=1, data and err held stable. On rsp_ready_i -> Idle.
//  Release:
//  - all_arrived = every port's registered state is Arrived.
//  - When set, in that same cycle: every port -> Respond with data_q=gen_q, err_q=0; gen_q <= gen_q+1.
//  - gen_q wraps modulo 2^DataWidth.
//  Latency:
//  - Last arrival handshake in cycle N -> rsp_valid_o high in cycle N+2 on all ports together.
//  - Error response: handshake in cycle N -> rsp_valid_o in cycle N+1.
//  Boundary cases:
//  - A port in Respond (error, or an unconsumed release) is not Arrived, so it blocks the next barrier.
//  - A released port can re-arrive only after its response has been accepted.
//  - NrPorts=1: every barrier request releases at N+2.
//  - rsp_ready_i held low: response is held indefinitely; other ports are unaffected.
//  - rsp_ready_i is ignored outside Respond. req_valid_i is ignored outside Idle.
//  - Async reset mid-barrier: pending arrivals are dropped, gen_q=0. No response is issued.
// STRUCTURE
//  barrier_pkg:
//  - barrier_state_e enum logic [1:0] {Idle, Arrived, Respond}.
//  - Default BarrierAddr constant.
//  Sub-module barrier_port_fsm: one instance per port via a generate loop.
//  - Holds state, data_q, err_q.
//  - Inputs: release, gen_q.
//  - Outputs: arrived flag, req/rsp handshake signals.
//  Top level: all_arrived AND-reduce and the gen_q counter.
// TESTING
//  - Reset, NrPorts=4, all valid=0 -> ready=4'b1111, rsp_valid=0, gen_q=0.
//  - Ports 0..3 send BarrierAddr in cycles 1,3,5,7:
//    - rsp_valid=4'b1111 at cycle 9, data=0 on all ports.
//    - Second barrier returns data=1.
//  - Port 2 sends 32'h0 -> rsp_valid[2] next cycle, err=1, data=0; other ports unaffected.
//  - Port 1 holds rsp_ready=0 after release; ports 0,2,3 re-arrive:
//    - No release until port 1 accepts and re-arrives.
//  - Reset asserted with 3 ports Arrived -> all Idle, no rsp_valid. Next full barrier returns data=0.
//  - Force gen_q = 2^DataWidth-1; complete two barriers -> data = all-ones, then 0.

Source files
------------

// File: rtl/barrier_pkg.sv
// Shared types and constants for the barrier responder.
package barrier_pkg;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Arrived = 2'd1,
        Respond = 2'd2
    } barrier_state_e;

    localparam logic [31:0] DefaultBarrierAddr = 32'h1234_beef;

endpackage

// File: rtl/barrier_port_fsm.sv
// One barrier participant: accepts a request, waits for release, then holds the response.
//
//   state   | meaning
//   Idle    | ready for a new request
//   Arrived | barrier request accepted, waiting for all ports
//   Respond | response (generation or error) held until accepted
module barrier_port_fsm
    import barrier_pkg::*;
#(
    parameter int                   AddrWidth   = 32,
    parameter int                   DataWidth   = 32,
    parameter logic [AddrWidth-1:0] BarrierAddr = AddrWidth'(DefaultBarrierAddr)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid,
    input  logic [AddrWidth-1:0] req_addr,
    output logic                 req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_data,
    output logic                 rsp_err,
    input  logic                 do_release,
    input  logic [DataWidth-1:0] gen,
    output logic                 arrived
);

    barrier_state_e       state_q, state_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Idle;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            Idle: begin
                // ready is masked during reset so no core sees a handshake that gets dropped
                req_ready = !rst_i;
                if (req_valid) begin
                    if (req_addr == BarrierAddr) begin
                        state_d = Arrived;
                    end else begin
                        state_d = Respond;
                        data_d  = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            Arrived: begin
                if (do_release) begin
                    state_d = Respond;
                    data_d  = gen;
                    err_d   = 1'b0;
                end
            end
            Respond: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    assign rsp_data = data_q;
    assign rsp_err  = err_q;
    assign arrived  = (state_q == Arrived);

endmodule

// File: rtl/barrier_responder.sv
// Memory-mapped barrier target: holds barrier requests until every port arrives, then releases all.
module barrier_responder
    import barrier_pkg::*;
#(
    parameter int                   NrPorts     = 4,
    parameter int                   AddrWidth   = 32,
    parameter int                   DataWidth   = 32,
    parameter logic [AddrWidth-1:0] BarrierAddr = AddrWidth'(DefaultBarrierAddr)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrPorts-1:0]             req_valid_i,
    input  logic [NrPorts*AddrWidth-1:0]   req_addr_i,
    output logic [NrPorts-1:0]             req_ready_o,
    output logic [NrPorts-1:0]             rsp_valid_o,
    input  logic [NrPorts-1:0]             rsp_ready_i,
    output logic [NrPorts*DataWidth-1:0]   rsp_data_o,
    output logic [NrPorts-1:0]             rsp_err_o
);

    logic [NrPorts-1:0]   arrived;
    logic                 all_arrived;
    logic [DataWidth-1:0] gen_q;

    assign all_arrived = &arrived;

    // generation advances once per completed barrier, wrapping naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gen_q <= '0;
        end else if (all_arrived) begin
            gen_q <= gen_q + DataWidth'(1);
        end
    end

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        barrier_port_fsm #(
            .AddrWidth   (AddrWidth),
            .DataWidth   (DataWidth),
            .BarrierAddr (BarrierAddr)
        ) u_port (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .req_valid  (req_valid_i[p]),
            .req_addr   (req_addr_i[p*AddrWidth +: AddrWidth]),
            .req_ready  (req_ready_o[p]),
            .rsp_valid  (rsp_valid_o[p]),
            .rsp_ready  (rsp_ready_i[p]),
            .rsp_data   (rsp_data_o[p*DataWidth +: DataWidth]),
            .rsp_err    (rsp_err_o[p]),
            .do_release (all_arrived),
            .gen        (gen_q),
            .arrived    (arrived[p])
        );
    end

endmodule

// File: tb/tb_barrier_responder.sv
// Bench for barrier_responder: event-level reference model plus directed and random stimulus.
module tb_barrier_responder;

    localparam int          NP = 4;
    localparam logic [31:0] BA = 32'h1234_beef;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic [NP-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [NP*32-1:0] req_addr, rsp_data;

    logic        s_valid, s_ready, s_rsp_valid, s_rsp_ready, s_err;
    logic [31:0] s_addr;
    logic [1:0]  s_data;

    barrier_responder dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err)
    );

    barrier_responder #(.NrPorts(1), .DataWidth(2)) dut_small (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (s_valid),
        .req_addr_i  (s_addr),
        .req_ready_o (s_ready),
        .rsp_valid_o (s_rsp_valid),
        .rsp_ready_i (s_rsp_ready),
        .rsp_data_o  (s_data),
        .rsp_err_o   (s_err)
    );

    // reference model: set of waiting ports, one response slot per port, generation count
    bit          m_wait [NP];
    bit          m_rsp  [NP];
    logic [31:0] m_data [NP];
    bit          m_err  [NP];
    logic [31:0] m_gen;
    int          m_releases;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_wait[p] = 0; m_rsp[p] = 0; m_data[p] = '0; m_err[p] = 0;
        end
        m_gen = '0;
    endtask

    task automatic model_edge();
        bit all;
        if (rst_i) begin
            model_reset();
            return;
        end
        all = 1;
        for (int p = 0; p < NP; p++) all &= m_wait[p];
        for (int p = 0; p < NP; p++) begin
            if (m_rsp[p]) begin
                if (rsp_ready[p]) m_rsp[p] = 0;
            end else if (m_wait[p]) begin
                if (all) begin
                    m_wait[p] = 0; m_rsp[p] = 1; m_data[p] = m_gen; m_err[p] = 0;
                end
            end else if (req_valid[p]) begin
                if (req_addr[p*32 +: 32] == BA) m_wait[p] = 1;
                else begin
                    m_rsp[p] = 1; m_data[p] = '0; m_err[p] = 1;
                end
            end
        end
        if (all) begin
            m_gen = m_gen + 1;
            m_releases++;
        end
    endtask

    task automatic compare();
        logic [NP-1:0] er, ev;
        for (int p = 0; p < NP; p++) begin
            er[p] = !rst_i && !m_wait[p] && !m_rsp[p];
            ev[p] = m_rsp[p];
        end
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        for (int p = 0; p < NP; p++) begin
            if (m_rsp[p]) begin
                chk($sformatf("rsp_data[%0d]", p), rsp_data[p*32 +: 32], m_data[p]);
                chk($sformatf("rsp_err[%0d]", p), rsp_err[p], m_err[p]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        compare();
    endtask

    task automatic set_req(input int p, input logic [31:0] a);
        req_valid[p]       = 1'b1;
        req_addr[p*32 +: 32] = a;
    endtask

    task automatic all_arrive();
        for (int p = 0; p < NP; p++) set_req(p, BA);
    endtask

    task automatic chk_all_data(input string name, input logic [31:0] exp);
        for (int p = 0; p < NP; p++)
            chk($sformatf("%s[%0d]", name, p), rsp_data[p*32 +: 32], exp);
    endtask

    logic [1:0] wrap_exp [6];
    int         gen_before;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = '0; req_addr = '0; rsp_ready = '0;
        s_valid = 0; s_addr = '0; s_rsp_ready = 0;
        m_releases = 0;
        model_reset();
        wrap_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (2) @(negedge clk_i);
        chk("ready_in_reset", req_ready, 4'b0000);
        chk("rsp_valid_in_reset", rsp_valid, 4'b0000);
        rst_i = 1'b0;
        #1;
        chk("ready_after_reset", req_ready, 4'b1111);
        chk("rsp_valid_after_reset", rsp_valid, 4'b0000);
        chk("rsp_data_after_reset", rsp_data, '0);
        chk("rsp_err_after_reset", rsp_err, 4'b0000);

        // staggered arrivals, release two edges after the last one
        for (int p = 0; p < NP; p++) begin
            set_req(p, BA);
            step();
            req_valid = '0;
            if (p == NP - 1) chk("no_early_release", rsp_valid, 4'b0000);
            step();
        end
        chk("release1_valid", rsp_valid, 4'b1111);
        chk_all_data("release1_data", 32'd0);
        chk("release1_err", rsp_err, 4'b0000);
        rsp_ready = '1; step(); rsp_ready = '0;
        chk("consumed1", rsp_valid, 4'b0000);

        all_arrive(); step(); req_valid = '0; step();
        chk("release2_valid", rsp_valid, 4'b1111);
        chk_all_data("release2_data", 32'd1);
        rsp_ready = '1; step(); rsp_ready = '0;

        set_req(2, 32'h0); step(); req_valid = '0;
        chk("err_valid", rsp_valid, 4'b0100);
        chk("err_flag", rsp_err[2], 1'b1);
        chk("err_data", rsp_data[64 +: 32], 32'd0);
        chk("err_others_ready", req_ready, 4'b1011);
        rsp_ready = 4'b0100; step(); rsp_ready = '0;

        // port 1 sits on its response and blocks the next barrier
        all_arrive(); step(); req_valid = '0; step();
        chk_all_data("release3_data", 32'd2);
        rsp_ready = 4'b1101; step(); rsp_ready = '0;
        set_req(0, BA); set_req(2, BA); set_req(3, BA);
        step(); req_valid = '0;
        repeat (3) step();
        chk("blocked_valid", rsp_valid, 4'b0010);
        chk("blocked_ready", req_ready, 4'b0000);
        rsp_ready = 4'b0010; step(); rsp_ready = '0;
        chk("port1_free", req_ready, 4'b0010);
        set_req(1, BA); step(); req_valid = '0; step();
        chk("release4_valid", rsp_valid, 4'b1111);
        chk_all_data("release4_data", 32'd3);
        rsp_ready = '1; step(); rsp_ready = '0;

        // reset while three ports wait
        set_req(0, BA); set_req(1, BA); set_req(2, BA);
        step(); req_valid = '0; step();
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("midreset_ready", req_ready, 4'b0000);
        chk("midreset_valid", rsp_valid, 4'b0000);
        step();
        rst_i = 1'b0;
        step();
        chk("postreset_valid", rsp_valid, 4'b0000);
        chk("postreset_ready", req_ready, 4'b1111);
        all_arrive(); step(); req_valid = '0; step();
        chk("postreset_release", rsp_valid, 4'b1111);
        chk_all_data("postreset_data", 32'd0);
        chk("model_gen_pin", m_gen, 32'd1);
        rsp_ready = '1; step(); rsp_ready = '0;

        gen_before = m_releases;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                req_valid[p] = ($urandom_range(0, 1) == 1);
                req_addr[p*32 +: 32] = ($urandom_range(0, 5) != 0) ? BA : $urandom;
                rsp_ready[p] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        chk("random_barriers_seen", (m_releases - gen_before) > 5, 1'b1);

        // small instance: single port, 2-bit generation wraps 3 -> 0
        req_valid = '0; rsp_ready = '1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("small_ready[%0d]", k), s_ready, 1'b1);
            s_valid = 1; s_addr = BA;
            step();
            s_valid = 0;
            chk($sformatf("small_wait[%0d]", k), s_rsp_valid, 1'b0);
            step();
            chk($sformatf("small_valid[%0d]", k), s_rsp_valid, 1'b1);
            chk($sformatf("small_data[%0d]", k), s_data, wrap_exp[k]);
            chk($sformatf("small_err[%0d]", k), s_err, 1'b0);
            s_rsp_ready = 1; step(); s_rsp_ready = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
